// File: rtl/sequence_player_pkg.sv
// Shared Genius game definitions: playback FSM encoding and default timing constants.
package sequence_player_pkg;

  localparam int unsigned GAME_ON_CYCLES  = 25_000_000;
  localparam int unsigned GAME_OFF_CYCLES = 12_500_000;
  localparam int unsigned GAME_N_LEDS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ON    = 3'd2,
    ST_OFF   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sequence_player_step_timer.sv
// Loadable down-counter that times the LED on and dark phases.
module sequence_player_step_timer #(
  parameter int unsigned TMR_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  input  logic             enable,
  output logic             zero_c
);

  logic [TMR_W-1:0] count;

  // Load has priority; counting saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays pattern memory entries 0..level on the colour LEDs, each lit for
// on_len cycles followed by an off_len dark gap, then flags end_FPGA.
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned N_LEDS     = GAME_N_LEDS,
  parameter int unsigned ON_CYCLES  = GAME_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = GAME_OFF_CYCLES,
  parameter int unsigned TMR_W      = 25
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] level,
  input  logic [1:0]        speed,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [N_LEDS-1:0] rom_data,
  output logic [N_LEDS-1:0] leds,
  output logic              busy,
  output logic              end_FPGA
);

  seq_state_e        state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [N_LEDS-1:0] leds_n;
  logic              busy_n;
  logic              end_n;
  logic              latch;
  logic [ADDR_W-1:0] level_q;
  logic [1:0]        speed_q;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_en;
  logic              tmr_zero;

  logic [31:0]       on_raw;
  logic [31:0]       off_raw;
  logic [TMR_W-1:0]  on_last;
  logic [TMR_W-1:0]  off_last;

  // Phase lengths scaled by the latched speed, clamped to at least one cycle.
  always_comb begin
    on_raw   = ON_CYCLES >> speed_q;
    off_raw  = OFF_CYCLES >> speed_q;
    on_last  = (on_raw == 32'd0)  ? '0 : TMR_W'(on_raw - 32'd1);
    off_last = (off_raw == 32'd0) ? '0 : TMR_W'(off_raw - 32'd1);
  end

  sequence_player_step_timer #(
    .TMR_W (TMR_W)
  ) u_step_timer (
    .clk    (CLOCK),
    .rst    (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .enable (tmr_en),
    .zero_c (tmr_zero)
  );

  // State, registered outputs and the level/speed captured at start.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      leds     <= '0;
      busy     <= 1'b0;
      end_FPGA <= 1'b0;
      level_q  <= '0;
      speed_q  <= '0;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      leds     <= leds_n;
      busy     <= busy_n;
      end_FPGA <= end_n;
      if (latch) begin
        level_q <= level;
        speed_q <= speed;
      end
    end
  end

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_n   = state;
    addr_n    = rom_addr;
    leds_n    = leds;
    busy_n    = busy;
    end_n     = end_FPGA;
    latch     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;

    if (abort) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      leds_n  = '0;
      busy_n  = 1'b0;
      end_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_n = ST_FETCH;
            addr_n  = '0;
            busy_n  = 1'b1;
            end_n   = 1'b0;
            latch   = 1'b1;
          end
        end
        ST_FETCH: begin
          state_n   = ST_ON;
          leds_n    = rom_data;
          tmr_load  = 1'b1;
          tmr_value = on_last;
        end
        ST_ON: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            state_n   = ST_OFF;
            leds_n    = '0;
            tmr_load  = 1'b1;
            tmr_value = off_last;
          end
        end
        ST_OFF: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            if (rom_addr == level_q) begin
              state_n = ST_DONE;
              busy_n  = 1'b0;
              end_n   = 1'b1;
            end else begin
              state_n = ST_FETCH;
              addr_n  = rom_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          addr_n  = '0;
          leds_n  = '0;
          busy_n  = 1'b0;
          end_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player with short on/off times.
module tb_sequence_player;

  logic       CLOCK;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] level;
  logic [1:0] speed;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] leds;
  logic       busy;
  logic       end_FPGA;

  logic [3:0] mem [16];
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] lvl;
    logic [1:0] spd;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [$];

  sequence_player #(
    .ADDR_W     (4),
    .N_LEDS     (4),
    .ON_CYCLES  (4),
    .OFF_CYCLES (2),
    .TMR_W      (8)
  ) dut (
    .CLOCK    (CLOCK),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .level    (level),
    .speed    (speed),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .leds     (leds),
    .busy     (busy),
    .end_FPGA (end_FPGA)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // rom_addr is a register inside the DUT, so this read path delivers the
  // entry one cycle after the edge that issued the address.
  assign rom_data = mem[rom_addr];
  assign obs = {rom_addr, leds, busy, end_FPGA};

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input int c, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s c=%0d got addr=%0d leds=%b busy=%b end=%b expected addr=%0d leds=%b busy=%b end=%b",
               name, c, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Expected outputs c cycles after the start edge (c=1 is the FETCH of step 0).
  function automatic logic [9:0] exp_play(input int lvl, input int on, input int off, input int c);
    int p;
    int k;
    int ph;
    logic [3:0] l;
    p = 1 + on + off;
    if (c > (lvl + 1) * p) return {4'(lvl), 4'd0, 1'b0, 1'b1};
    k  = (c - 1) / p;
    ph = (c - 1) % p;
    l  = (ph >= 1 && ph <= on) ? 4'(1 << (k % 4)) : 4'd0;
    return {4'(k), l, 1'b1, 1'b0};
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic [3:0] l, input logic [1:0] sp,
                              input logic [3:0] ea, input logic [3:0] el, input logic eb, input logic ee);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.lvl   = l;
    v.spd   = sp;
    v.exp   = {ea, el, eb, ee};
    return v;
  endfunction

  task automatic play(input string name, input int lvl, input int spd, input int on, input int off, input int n);
    level = 4'(lvl);
    speed = 2'(spd);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      check(name, c, obs, exp_play(lvl, on, off, c));
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    level = 4'd0;
    speed = 2'd0;

    tick();
    check("reset", 0, obs, 10'd0);
    reset = 1'b0;

    // Idle with no start: everything stays low.
    for (int c = 1; c <= 20; c++) begin
      tick();
      check("idle", c, obs, 10'd0);
    end

    // Three steps at full length; done visible at cycle 22 and held.
    play("lvl2_spd0", 2, 0, 4, 2, 26);

    // Table: single short step, restart from DONE, abort beating start.
    tbl.push_back(mk(1'b0, 1'b1, 4'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 2'd2, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 2'd2, 4'd0, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 2'd2, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 2'd2, 4'd0, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 2'd2, 4'd0, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'd1, 2'd3, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd0, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd1, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd1, 4'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd1, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd1, 2'd3, 4'd1, 4'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'd3, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3, 2'd1, 4'd0, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3, 2'd1, 4'd0, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3, 2'd1, 4'd1, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'd3, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      start = tbl[i].start;
      abort = tbl[i].abort;
      level = tbl[i].lvl;
      speed = tbl[i].spd;
      tick();
      check("vec", i, obs, tbl[i].exp);
    end
    start = 1'b0;
    abort = 1'b0;

    // start pulsed during ON of step 1 with new level/speed: no effect.
    level = 4'd2;
    speed = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      check("restart_ignored", c, obs, exp_play(2, 4, 2, c));
      if (c == 9) begin
        start = 1'b1;
        level = 4'd5;
        speed = 2'd3;
      end else if (c == 11) begin
        start = 1'b0;
      end
      tick();
    end
    level = 4'd2;
    speed = 2'd0;

    // abort together with start during OFF of step 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check("pre_abort", c, obs, exp_play(2, 4, 2, c));
      if (c < 13) tick();
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort", 14, obs, 10'd0);
    tick();
    check("abort_idle", 15, obs, 10'd0);
    play("after_abort", 0, 0, 4, 2, 10);

    // Full memory: address stops at 15 without wrapping.
    play("lvl15_spd3", 15, 3, 1, 1, 52);

    // Asynchronous reset while step 1 is lit.
    level = 4'd2;
    speed = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check("pre_reset", c, obs, exp_play(2, 4, 2, c));
      if (c < 9) tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 0, obs, 10'd0);
    tick();
    tick();
    check("reset_hold", 0, obs, 10'd0);
    reset = 1'b0;
    tick();
    play("after_reset", 1, 0, 4, 2, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Playback scheduler for the Genius game. It plays the stored colour sequence to the player before the player's input phase.
- Steps through pattern memory from address 0 to the current level. Each entry is lit on the 4 colour LEDs for a programmable on-time, followed by a dark gap.
- Raises end_FPGA when playback finishes; the game control FSM uses it to hand over to the user phase.
- Sits between the control FSM (start/abort) and the datapath's pattern memory and LED outputs.

Parameters:
- ADDR_W, 4, width of pattern memory address and of level.
- N_LEDS, 4, number of colour LEDs / width of a pattern entry.
- ON_CYCLES, 25000000, base LED on-time in clock cycles (0.5 s at 50 MHz).
- OFF_CYCLES, 12500000, base dark gap in clock cycles.
- TMR_W, 25, timer width; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- CLOCK, input, 1, system clock (50 MHz).
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, begin playback; sampled only in IDLE or DONE.
- abort, input, 1, synchronous cancel; wins over every other input.
- level, input, ADDR_W, index of the last step to play; steps 0..level are played.
- speed, input, 2, time scaler: on/off lengths are shifted right by speed.
- rom_addr, output, ADDR_W, pattern memory address.
- rom_data, input, N_LEDS, pattern entry; memory is synchronous with 1-cycle read latency.
- leds, output, N_LEDS, colour LED drive.
- busy, output, 1, high while playback is in progress.
- end_FPGA, output, 1, playback complete; held until the next start, abort or reset.

Behaviour:
- Reset: state IDLE; rom_addr=0, leds=0, busy=0, end_FPGA=0, timer=0. All outputs are registered.
- States: IDLE, FETCH, ON, OFF, DONE.
- IDLE/DONE, start=1 at edge t:
  - Go to FETCH at t+1 with rom_addr=0, busy=1, end_FPGA=0.
  - level and speed are latched at this edge.
- FETCH: lasts exactly 1 cycle (memory latency). Next state ON; leds<=rom_data; timer loaded with on_len-1.
- ON:
  - leds held; timer decrements each cycle.
  - At timer==0: leds<=0, timer<=off_len-1, go to OFF.
  - ON therefore lasts exactly on_len cycles.
- OFF: lasts off_len cycles. At timer==0:
  - If rom_addr==latched level: go to DONE, busy<=0, end_FPGA<=1.
  - Else: rom_addr<=rom_addr+1, go to FETCH.
- Lengths: on_len = max(1, ON_CYCLES>>speed); off_len = max(1, OFF_CYCLES>>speed).
- Total playback time from start to end_FPGA = 1 + (level+1)×(1+on_len+off_len) cycles.
- level=0: exactly one step is played.
- level=2^ADDR_W-1: plays all entries. rom_addr never wraps; comparison ends playback first.
- start while busy (FETCH/ON/OFF): ignored. Latched level and speed do not change mid-playback.
- start in DONE: restarts playback from address 0; end_FPGA clears on the same edge.
- abort=1 in any state: next state IDLE; leds=0, busy=0, end_FPGA=0, rom_addr=0. abort beats a simultaneous start.
- rom_data is driven to leds unmodified, including non-one-hot values and 0.
- reset asserted mid-playback: outputs go to reset values immediately (asynchronous).

Decomposition:
- Shared game package holds:
  - state encoding for sequence_player (IDLE=0, FETCH=1, ON=2, OFF=3, DONE=4, 3-bit);
  - default timing constants ON_CYCLES and OFF_CYCLES, shared with the end_time timer in the datapath;
  - N_LEDS.
- One natural sub-module: step_timer, a loadable down-counter (load, value, enable, zero flag, TMR_W wide), instantiated once.

Test Plan (bench uses ON_CYCLES=4, OFF_CYCLES=2, ADDR_W=4; memory preloaded 1,2,4,8,...):
- Reset then idle: all outputs 0 for 20 cycles with start=0.
- level=2, speed=0, start pulse at cycle t:
  - FETCH addresses 0, 1, 2;
  - leds = 1, 2, 4, each for 4 cycles, separated by 2 dark cycles;
  - end_FPGA=1 and busy=0 at t+22 and held.
- level=0, speed=2 (on_len=1, off_len=1): single step with leds=1 for 1 cycle; end_FPGA rises at t+4.
- start re-pulsed during the ON of step 1: ignored; the sequence and completion cycle are identical to the undisturbed run.
- abort and start asserted together during OFF of step 1: next cycle IDLE, leds=0, busy=0, end_FPGA=0. A later start plays again from address 0.
- reset asserted asynchronously mid-ON with leds=2: leds, busy and rom_addr go to 0 before the next clock edge. After release, start gives normal playback.
